// File: rtl/atan2_cordic_if.sv
// Handshake bundle for the atan2 CORDIC: Cartesian sample in, 32-bit phase out.
// The master side drives the sample and consumes the phase; the slave side is the CORDIC core.
interface atan2_cordic_if;
    logic signed [31:0] x_i;
    logic signed [31:0] y_i;
    logic               valid_i;
    logic               ready_o;
    logic        [31:0] phase_o;
    logic               valid_o;
    logic               ready_i;

    modport master (
        output x_i, y_i, valid_i, ready_i,
        input  ready_o, phase_o, valid_o
    );

    modport slave (
        input  x_i, y_i, valid_i, ready_i,
        output ready_o, phase_o, valid_o
    );
endinterface

// File: rtl/atan2_cordic.sv
// Iterative vectoring-mode CORDIC: converts a Q2.30 (x, y) pair into a 32-bit phase
// (radian / 2pi * 2^32), one micro-rotation per clock.
module atan2_cordic #(
    parameter int ITERATIONS = 30,
    parameter int GUARD_BITS = 3
) (
    input  logic          clk,
    input  logic          resetn,
    atan2_cordic_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int W      = 36 + GUARD_BITS;

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t              state, state_nx;
    logic [4:0]          iter;
    logic                zero_q;
    logic [31:0]         phase_q;
    logic signed [W-1:0] x_r, y_r;
    logic [31:0]         z_r;
    logic signed [W-1:0] x_nx, y_nx;
    logic [31:0]         z_nx;
    logic                accept;
    logic                last;

    function automatic logic [31:0] atan_tab(input logic [4:0] i);
        case (i)
            5'd0:  atan_tab = 32'h2000_0000;
            5'd1:  atan_tab = 32'h12E4_051E;
            5'd2:  atan_tab = 32'h09FB_385B;
            5'd3:  atan_tab = 32'h0511_11D4;
            5'd4:  atan_tab = 32'h028B_0D43;
            5'd5:  atan_tab = 32'h0145_D7E1;
            5'd6:  atan_tab = 32'h00A2_F61E;
            5'd7:  atan_tab = 32'h0051_7C55;
            5'd8:  atan_tab = 32'h0028_BE53;
            5'd9:  atan_tab = 32'h0014_5F2F;
            5'd10: atan_tab = 32'h000A_2F98;
            5'd11: atan_tab = 32'h0005_17CC;
            5'd12: atan_tab = 32'h0002_8BE6;
            5'd13: atan_tab = 32'h0001_45F3;
            5'd14: atan_tab = 32'h0000_A2FA;
            5'd15: atan_tab = 32'h0000_517D;
            5'd16: atan_tab = 32'h0000_28BE;
            5'd17: atan_tab = 32'h0000_145F;
            5'd18: atan_tab = 32'h0000_0A30;
            5'd19: atan_tab = 32'h0000_0518;
            5'd20: atan_tab = 32'h0000_028C;
            5'd21: atan_tab = 32'h0000_0146;
            5'd22: atan_tab = 32'h0000_00A3;
            5'd23: atan_tab = 32'h0000_0051;
            5'd24: atan_tab = 32'h0000_0029;
            5'd25: atan_tab = 32'h0000_0014;
            5'd26: atan_tab = 32'h0000_000A;
            5'd27: atan_tab = 32'h0000_0005;
            5'd28: atan_tab = 32'h0000_0003;
            5'd29: atan_tab = 32'h0000_0001;
            5'd30: atan_tab = 32'h0000_0001;
            default: atan_tab = 32'h0000_0000;
        endcase
    endfunction

    // Four extra integer bits cover CORDIC gain times the diagonal of the +/-2 square.
    function automatic logic signed [W-1:0] widen(input logic signed [DATA_W-1:0] v);
        widen = {{(W - DATA_W - GUARD_BITS){v[DATA_W-1]}}, v, {GUARD_BITS{1'b0}}};
    endfunction

    assign accept = bus.valid_i && (state == IDLE);
    assign last   = (iter == 5'(ITERATIONS - 1));

    always_comb begin
        state_nx    = state;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        bus.phase_o = phase_q;
        case (state)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) state_nx = ROT;
            end
            ROT: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                bus.valid_o = 1'b1;
                if (bus.ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Micro-rotation toward the +x axis; both shifts use the pre-update x/y.
    always_comb begin
        x_nx = x_r;
        y_nx = y_r;
        z_nx = z_r;
        if (!y_r[W-1]) begin
            x_nx = x_r + (y_r >>> iter);
            y_nx = y_r - (x_r >>> iter);
            z_nx = z_r + atan_tab(iter);
        end else begin
            x_nx = x_r - (y_r >>> iter);
            y_nx = y_r + (x_r >>> iter);
            z_nx = z_r - atan_tab(iter);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            iter    <= 5'd0;
            zero_q  <= 1'b0;
            phase_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                iter   <= 5'd0;
                zero_q <= (bus.x_i == 32'sd0) && (bus.y_i == 32'sd0);
            end else if (state == ROT) begin
                iter <= iter + 5'd1;
                if (last) phase_q <= zero_q ? 32'h0 : z_nx;
            end
        end
    end

    // Datapath registers carry no reset; the FSM alone decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.x_i[DATA_W-1]) begin
                x_r <= -widen(bus.x_i);
                y_r <= -widen(bus.y_i);
                z_r <= 32'h8000_0000;
            end else begin
                x_r <= widen(bus.x_i);
                y_r <= widen(bus.y_i);
                z_r <= 32'h0;
            end
        end else if (state == ROT) begin
            x_r <= x_nx;
            y_r <= y_nx;
            z_r <= z_nx;
        end
    end
endmodule

// File: doc/atan2_cordic.md
Name: atan2_cordic

Overview:
- Inverse of the sine path: takes a Cartesian pair (x = cos-like, y = sin-like) in Q2.30 and returns its 32-bit phase.
- Phase uses the same format the sine generator consumes: radian / (2*pi) * 2^32, so a phase → sin/cos → atan2_cordic round trip returns the original phase within tolerance.
- Iterative CORDIC in vectoring mode, one micro-rotation per clock.
- Valid/ready handshake on both input and output; used for phase-detector and NCO-correction loops.

Parameters:
- ITERATIONS, 30, number of micro-rotations; legal range 16..31; sets latency and accuracy.
- GUARD_BITS, 3, extra fractional LSBs carried on x/y below Q2.30 to limit truncation error.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- x_i  input  32  signed Q2.30 x (cos) component.
- y_i  input  32  signed Q2.30 y (sin) component.
- valid_i  input  1  x_i/y_i valid.
- ready_o  output  1  block can accept an input this cycle.
- phase_o  output  32  unsigned phase, radian/(2*pi)*2^32, modulo 2^32.
- valid_o  output  1  phase_o valid.
- ready_i  input  1  downstream accepts phase_o.

Behaviour:
- Reset: state IDLE; ready_o=1, valid_o=0, phase_o=0, iteration counter=0. Reset asserted mid-operation discards the in-flight sample; no output is produced for it.
- FSM IDLE / ROT / DONE.
  - IDLE: ready_o=1. On valid_i&&ready_o, latch inputs and pre-rotate into x,y,z, clear counter i, go ROT.
  - ROT: ready_o=0. Perform one iteration per cycle. At i==ITERATIONS-1, go DONE.
  - DONE: valid_o=1, phase_o stable. On ready_i, go IDLE (valid_o=0 the next cycle).
- Latency: valid_o rises at the ITERATIONS-th rising edge after the accept edge. Minimum spacing between accepts is ITERATIONS+2 cycles with ready_i held high.
- valid_i while ready_o=0 is ignored; the upstream must hold it. phase_o and valid_o must not change while valid_o=1 and ready_i=0.
- Datapath width: x,y sign-extended to 36 integer+sign bits plus GUARD_BITS fraction. Q2.30 range ±2, CORDIC gain 1.647 and the √2 diagonal give growth < 4.7, so there is no overflow. Negating -2.0 (0x8000_0000) is legal.
- Pre-rotation:
  - If x<0: x=-x, y=-y, z=0x8000_0000.
  - Else: z=0.
- Iteration i:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=T[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=T[i].
  - Shifts are arithmetic and use pre-update values. z is 32-bit with wrap-around.
- Table: T[i]=round(atan(2^-i)/(2*pi)*2^32). T[0]=0x20000000, T[1]=0x12E4051E. Constant ROM/case of 32 entries.
- Output: phase_o=z after the final iteration; no magnitude output and no gain correction needed.
- Zero input: x_i==0 and y_i==0 forces phase_o=0x00000000. Same latency; a flag is latched at accept.
- Accuracy (ITERATIONS=30, GUARD_BITS=3, |(x,y)|>=0.25): |phase_o - ideal| <= 256 LSB, measured modulo 2^32 (wrap-aware). Accuracy below magnitude 2^-20 is not specified.

Test Plan:
- Axes, ready_i=1: (x,y)=(0x40000000,0) → 0x00000000; (0,0x40000000) → 0x40000000; (0xC0000000,0) → 0x80000000; (0,0xC0000000) → 0xC0000000. Each within ±256 LSB wrap-aware; valid_o exactly 30 cycles after accept.
- Diagonals (±0x2D413CCD, ±0x2D413CCD) → 0x20000000, 0x60000000, 0xA0000000, 0xE0000000, each ±256. Extremes (0x80000000,0x7FFFFFFF) give no overflow: result ≈ 0x60000000 ±256.
- Round trip: 10k random phases p → floating cos/sin quantised to Q2.30 → phase_o within ±256 of p. Scaled inputs at magnitude 0.25 and 1.9 give the same bound.
- Zero input (0,0) → phase_o=0x00000000, valid_o after 30 cycles.
- Backpressure: ready_i=0 for 20 cycles after valid_o → phase_o/valid_o stable and ready_o=0. A valid_i pulse during this window is not accepted; the next accept occurs only after a ready_i handshake.
- Reset: drop resetn at ROT iteration 10 → ready_o=1, valid_o=0 immediately. A new input after release yields the correct result with normal latency and no stale output.
